dmux4way16_stream: RTL
======================

# dmux4way16_stream

Registered 1-to-4 demultiplexer for 16-bit words; the inverse of the 4-way 16-bit mux. Accepts one word per cycle on a valid/ready input, steers it by `in_sel` into one of four per-way FIFOs, and presents each way as an independent valid/ready output. It distributes a shared 16-bit bus to four consumers without losing words under backpressure.

## Interface
- `DEPTH`, 2: entries per way FIFO; power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  selected way can accept.
- `in_sel`  in  2  destination way; `2'b00`→way0 … `2'b11`→way3. Matches mux `sel` ordering: way0↔`in1`, way3↔`in4`.
- `in_data`  in  16  input word.
- `out_valid`  out  4  bit i: way i FIFO non-empty.
- `out_ready`  in  4  bit i: consumer i takes head word.
- `out_data`  out  64  way i head word on bits `[16*i+15:16*i]`.
- `level`  out  4×($clog2(DEPTH)+1), packed  way i occupancy.

## Operation
- Push: `in_valid && in_ready` at a rising edge writes `in_data` to way `in_sel`.
- `in_ready = !full[in_sel]`. Combinational from `in_sel` and registered state only; no path from `out_ready`.
- Pop: `out_valid[i] && out_ready[i]` at an edge advances way i head. Ways pop independently; all four may pop in one cycle.
- `out_data` for way i is the registered FIFO head. It is undefined while `out_valid[i]=0`, but must not be X after reset; RAM is reset to 0.
- Per-way FIFO: write pointer, read pointer, and count (0..DEPTH). Pointers wrap modulo DEPTH.
- Derived way states:
  - EMPTY: count=0.
  - PARTIAL: 0<count<DEPTH.
  - FULL: count=DEPTH.
- State transitions:
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop to the same way in the same cycle: count unchanged, both pointers advance.
- Boundaries:
  - Push to a FULL way: blocked (`in_ready=0`), even if that way pops in the same cycle.
  - Pop on EMPTY: impossible, because `out_valid=0`.
  - Simultaneous push and pop on a way with DEPTH−1 entries: ends with DEPTH−1 entries.
  - `in_sel` may change any cycle while `in_valid=0`. While `in_valid=1 && !in_ready`, the source must hold `in_sel`/`in_data` stable; a source that changes them redirects the offer, with no protection.
- Ordering: words to the same way exit in acceptance order. No ordering is guaranteed across ways.

## Timing
- Reset (async assert, sync-safe deassert handled upstream):
  - `out_valid=4'b0000`, all `level=0`, pointers 0, `out_data=0`.
  - `in_ready=1` for every `in_sel`.
- Latency: a word accepted at edge k gives `out_valid` high after edge k, so a consumer can take it at edge k+1. Minimum latency is 1 cycle.
- Throughput: 1 word/cycle in. Up to 1 word/cycle per way out.
- A way that pops at edge k and was FULL shows `in_ready=1` (when selected) after edge k, a 1-cycle bubble by design.
- Reset asserted mid-traffic: all buffered words are discarded immediately. Outputs take reset values asynchronously.

## Structure
- Shared package `hack_bus_pkg`:
  - `WORD_W=16`, `NUM_WAYS=4`.
  - typedef `word_t` (16 bits), typedef `way_sel_t` (2 bits).
  - Also consumed by the existing mux variants when they are ported.
- One sub-module, `dmux_way_fifo` (`DEPTH`-entry synchronous FIFO with push, pop, full, empty, level, head), instantiated 4× by generate.
- Top level holds only the `in_sel` decode (one-hot push enables) and the `in_ready` select.

## Test plan
- Reset then single words: `in_sel=2`, `in_data=16'hBEEF`, `out_ready=0` → after the edge, `out_valid=4'b0100`, way2 data `BEEF`, `level[2]=1`, other ways untouched.
- Fill to full: with DEPTH=2, push `0001`,`0002` to way0 with `out_ready=0` → `in_ready=0` for `sel=0` while `in_ready=1` for `sel=1`. Release `out_ready[0]` → the consumer sees `0001` then `0002`.
- Simultaneous push and pop: way3 holds 1 word (`AAAA`), push `BBBB` with `out_ready[3]=1` in the same cycle → `level[3]` stays 1 and the head becomes `BBBB`.
- Full way plus same-cycle pop: way1 is FULL, `out_ready[1]=1`, `in_valid=1`, `sel=1` → the push is not accepted that cycle and is accepted on the next edge.
- Round-robin stress: 1000 random words with random `sel` and random `out_ready` → per-way scoreboard order matches, no loss or duplication, `level` never exceeds DEPTH.
- Mid-traffic reset: pull `rst_n` low between edges with all ways holding data → `out_valid` goes to 0 asynchronously, and after release all `level=0`.

Source files
------------

// File: rtl/hack_bus_pkg.sv
// Shared types for the Hack 16-bit bus mux/demux family.
// Word width, way count and the way-select decode used by every variant.
package hack_bus_pkg;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned NUM_WAYS = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [1:0]        way_sel_t;

    // Binary way select to one-hot enable; bit i selects way i.
    function automatic logic [NUM_WAYS-1:0] sel_onehot(input way_sel_t sel);
        logic [NUM_WAYS-1:0] oh;
        oh = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dmux_way_fifo.sv
// DEPTH-entry synchronous FIFO for one demux way.
// Head is read straight from registered storage, so it is valid the cycle after a push.
module dmux_way_fifo
    import hack_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  word_t            wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output word_t            head
);

    word_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

    // Full blocks a push even when the same cycle pops; this keeps in_ready off out_ready.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        level_d = level_q;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointers are PTR_W wide and DEPTH is a power of two, so they wrap for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/dmux4way16_stream.sv
// Registered 1-to-4 demultiplexer for 16-bit words with a FIFO per way.
// Only the in_sel decode and in_ready select live here; buffering is in dmux_way_fifo.
module dmux4way16_stream
    import hack_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_sel,
    input  logic [WORD_W-1:0]          in_data,
    output logic [NUM_WAYS-1:0]        out_valid,
    input  logic [NUM_WAYS-1:0]        out_ready,
    output logic [NUM_WAYS*WORD_W-1:0] out_data,
    output logic [NUM_WAYS*LVL_W-1:0]  level
);

    logic [NUM_WAYS-1:0] way_push;
    logic [NUM_WAYS-1:0] way_full;
    logic [NUM_WAYS-1:0] way_empty;
    logic                accept;

    assign in_ready  = !way_full[in_sel];
    assign accept    = in_valid && in_ready;
    assign way_push  = accept ? sel_onehot(way_sel_t'(in_sel)) : '0;
    assign out_valid = ~way_empty;

    for (genvar i = 0; i < NUM_WAYS; i++) begin : g_way
        dmux_way_fifo #(
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (way_push[i]),
            .wdata (in_data),
            .pop   (out_ready[i]),
            .full  (way_full[i]),
            .empty (way_empty[i]),
            .level (level[LVL_W*i +: LVL_W]),
            .head  (out_data[WORD_W*i +: WORD_W])
        );
    end

endmodule
